ps2_keyboard_rx: RTL and testbench

Parametrised PS/2 device-to-host receiver with a configurable-depth first-word-fall-through scancode FIFO. It is the next-generation keyboard front end on the SoC peripheral bus.
- Added over the current receiver: ps2_clk glitch filtering, full 11-bit frame checking including the stop bit, and a mid-frame timeout with resync.
- Also added: FIFO level/full status and per-frame error pulses.
- The CPU reads scancodes with the same active-low rdn strobe as the existing keyboard port.

---
 rtl/ps2_keyboard_rx.sv | 188 ++++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: glitch-filtered clock, 11-bit frame check, timeout resync, FWFT FIFO.
// Optional macro PS2_MAKEBREAK_EN folds E0/F0 prefix bytes into bits [9:8] of the following code.
module ps2_keyboard_rx #(
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned FILTER  = 8,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  input  logic              rdn,
  output logic [9:0]        data,
  output logic              ready,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              parity_err,
  output logic              frame_err
);

  localparam int unsigned Depth = 1 << ADDR_W;
  localparam int unsigned FW    = (FILTER > 2) ? $clog2(FILTER) : 1;
  localparam int unsigned TW    = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0]     FiltMax  = FW'(FILTER - 1);
  localparam logic [TW-1:0]     TmoMax   = TW'(TIMEOUT);
  localparam logic [ADDR_W:0]   LevelMax = (ADDR_W + 1)'(Depth);

  typedef enum logic [1:0] {StIdle, StRecv, StCheck} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_q, filt_prev;
  logic [FW-1:0] filt_cnt;
  logic          sample;

  state_t        state;
  logic [3:0]    bit_idx;
  logic [TW-1:0] tmo_cnt;
  logic [9:0]    shreg;
  logic          frame_ok;
  logic          push_req;
  logic [9:0]    push_word;

  logic [9:0]        mem [Depth];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              pop, do_push;

  // Input synchronisers and ps2_clk glitch filter.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      dat_s1    <= 1'b1;
      dat_s2    <= 1'b1;
      filt_q    <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      clk_s1    <= ps2_clk;
      clk_s2    <= clk_s1;
      dat_s1    <= ps2_data;
      dat_s2    <= dat_s1;
      filt_prev <= filt_q;
      if (clk_s2 == filt_q) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FiltMax) begin
        filt_q   <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign sample = filt_prev & ~filt_q;

  // Odd parity: data bits and parity bit together must XOR to 1.
  assign frame_ok = shreg[9] & (^shreg[8:0]);

`ifdef PS2_MAKEBREAK_EN
  logic ext_pend, brk_pend;
  logic is_prefix;

  assign is_prefix = (shreg[7:0] == 8'hE0) || (shreg[7:0] == 8'hF0);
  assign push_req  = (state == StCheck) && frame_ok && !is_prefix;
  assign push_word = {ext_pend, brk_pend, shreg[7:0]};
`else
  assign push_req  = (state == StCheck) && frame_ok;
  assign push_word = {2'b00, shreg[7:0]};
`endif

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state      <= StIdle;
      bit_idx    <= '0;
      tmo_cnt    <= '0;
      shreg      <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PS2_MAKEBREAK_EN
      ext_pend   <= 1'b0;
      brk_pend   <= 1'b0;
`endif
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        StIdle: begin
          if (sample && !dat_s2) begin
            state   <= StRecv;
            bit_idx <= '0;
            tmo_cnt <= '0;
          end
        end
        StRecv: begin
          if (sample) begin
            shreg   <= {dat_s2, shreg[9:1]};
            tmo_cnt <= '0;
            if (bit_idx == 4'd9) state <= StCheck;
            else                 bit_idx <= bit_idx + 1'b1;
          end else if (tmo_cnt == TmoMax) begin
            frame_err <= 1'b1;
            state     <= StIdle;
`ifdef PS2_MAKEBREAK_EN
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
`endif
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        StCheck: begin
          state <= StIdle;
          if (!shreg[9]) begin
            frame_err <= 1'b1;
          end else if (!(^shreg[8:0])) begin
            parity_err <= 1'b1;
          end
`ifdef PS2_MAKEBREAK_EN
          if (!frame_ok) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
          end else if (shreg[7:0] == 8'hE0) begin
            ext_pend <= 1'b1;
          end else if (shreg[7:0] == 8'hF0) begin
            brk_pend <= 1'b1;
          end else begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
          end
`endif
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign ready   = (level != '0);
  assign full    = (level == LevelMax);
  assign pop     = ~rdn & ready;
  // A push into a full FIFO only lands if a pop frees a slot in the same cycle.
  assign do_push = push_req & (~full | pop);
  assign data    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (clrn && do_push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (pop)                   overflow <= 1'b0;
      else if (push_req && full) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx; expected entries are modelled as frames are sent.
// Honours PS2_MAKEBREAK_EN when the macro is defined for the build.
module tb_ps2_keyboard_rx;

  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned FILTER  = 8;
  localparam int unsigned TIMEOUT = 1000;
  localparam int          DEPTH   = 1 << ADDR_W;
  localparam int          H       = 20;

  logic            clk = 1'b0;
  logic            clrn = 1'b0;
  logic            ps2_clk = 1'b1;
  logic            ps2_data = 1'b1;
  logic            rdn = 1'b1;
  logic [9:0]      data;
  logic            ready, full, overflow, parity_err, frame_err;
  logic [ADDR_W:0] level;

  ps2_keyboard_rx #(.ADDR_W(ADDR_W), .FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rdn(rdn),
    .data(data), .ready(ready), .full(full), .level(level), .overflow(overflow),
    .parity_err(parity_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int pe_cnt = 0;
  int fe_cnt = 0;
  int exp_pe = 0;
  int exp_fe = 0;

  logic [9:0] exp_q[$];
  bit m_ext = 0;
  bit m_brk = 0;
  bit m_ovf = 0;

  always @(negedge clk) begin
    if (clrn && parity_err) pe_cnt++;
    if (clrn && frame_err)  fe_cnt++;
  end

  task automatic model_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad);
    logic [9:0] w;
    if (stop_bad) begin exp_fe++; m_ext = 0; m_brk = 0; return; end
    if (par_bad)  begin exp_pe++; m_ext = 0; m_brk = 0; return; end
`ifdef PS2_MAKEBREAK_EN
    if (b == 8'hE0) begin m_ext = 1; return; end
    if (b == 8'hF0) begin m_brk = 1; return; end
    w = {m_ext, m_brk, b};
    m_ext = 0;
    m_brk = 0;
`else
    w = {2'b00, b};
`endif
    if (exp_q.size() < DEPTH) exp_q.push_back(w);
    else m_ovf = 1;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (H) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (H) @(posedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad);
    logic par;
    par = (~^b) ^ par_bad;
    send_bits({~stop_bad, par, b, 1'b0}, 11);
    repeat (H) @(posedge clk);
    model_frame(b, par_bad, stop_bad);
  endtask

  task automatic read_check(input string name);
    int k;
    logic [9:0] e;
    k = 0;
    @(negedge clk);
    while (!ready && k < 2000) begin @(negedge clk); k++; end
    n_cmp++;
    if (!ready || exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: ready=%0b with %0d expected entries, required ready=1 and a queued entry",
               name, ready, exp_q.size());
      return;
    end
    e = exp_q.pop_front();
    if (data !== e) begin
      n_err++;
      $display("FAIL %s: data=%03h required %03h", name, data, e);
    end
    m_ovf = 0;
    rdn = 1'b0;
    @(negedge clk);
    rdn = 1'b1;
  endtask

  task automatic drain(input string name);
    while (exp_q.size() > 0) read_check(name);
  endtask

  task automatic check_status(input string name);
    @(negedge clk);
    n_cmp++;
    if (level !== (ADDR_W+1)'(exp_q.size()) || full !== (exp_q.size() == DEPTH) ||
        ready !== (exp_q.size() != 0) || overflow !== m_ovf) begin
      n_err++;
      $display("FAIL %s: level=%0d full=%0b ready=%0b ovf=%0b required %0d %0b %0b %0b", name,
               level, full, ready, overflow, exp_q.size(), exp_q.size() == DEPTH,
               exp_q.size() != 0, m_ovf);
    end
  endtask

  task automatic check_errs(input string name);
    @(negedge clk);
    n_cmp++;
    if (pe_cnt !== exp_pe || fe_cnt !== exp_fe) begin
      n_err++;
      $display("FAIL %s: parity_err count=%0d frame_err count=%0d required %0d %0d",
               name, pe_cnt, fe_cnt, exp_pe, exp_fe);
    end
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({ready, full, level, overflow, parity_err, frame_err} !== '0) begin
      n_err++;
      $display("FAIL reset: ready=%0b full=%0b level=%0d ovf=%0b pe=%0b fe=%0b required all 0",
               ready, full, level, overflow, parity_err, frame_err);
    end
    clrn = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_single();
    send_frame(8'h1C, 0, 0);
    check_status("single_status");
    read_check("single_data");
    check_status("single_after_pop");
  endtask

  task automatic test_parity();
    send_frame(8'h1C, 1, 0);
    check_errs("parity_pulse");
    check_status("parity_no_push");
    send_frame(8'h32, 0, 0);
    read_check("after_parity");
  endtask

  task automatic test_stop_bit();
    send_frame(8'h5A, 0, 1);
    check_errs("stop_bit_err");
    check_status("stop_bit_no_push");
  endtask

  task automatic test_timeout();
    send_bits(11'b00000111000, 5);
    repeat (TIMEOUT + 10 + H) @(posedge clk);
    exp_fe++;
    m_ext = 0;
    m_brk = 0;
    check_errs("timeout_pulse");
    check_status("timeout_no_push");
    send_frame(8'h1C, 0, 0);
    read_check("after_timeout");
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0);
    check_status("overflow_status");
    read_check("overflow_first");
    check_status("overflow_cleared");
    drain("overflow_drain");
    check_status("overflow_empty");
  endtask

  task automatic test_push_pop_full();
    for (int i = 0; i < DEPTH; i++) send_frame(8'h10 + 8'(i), 0, 0);
    check_status("ppf_full");
    fork
      send_frame(8'h55, 0, 0);
      begin
        int k;
        logic [9:0] e;
        k = 0;
        @(negedge clk);
        while (!dut.push_req && k < 2000) begin @(negedge clk); k++; end
        n_cmp++;
        e = exp_q.pop_front();
        if (!dut.push_req || data !== e) begin
          n_err++;
          $display("FAIL ppf_pop: data=%03h push_seen=%0b required %03h with push", data,
                   dut.push_req, e);
        end
        rdn = 1'b0;
        @(negedge clk);
        rdn = 1'b1;
      end
    join
    check_status("ppf_after");
    drain("ppf_drain");
  endtask

  task automatic test_glitch();
    ps2_data = 1'b0;
    repeat (H) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (2 * H) @(posedge clk);
    ps2_data = 1'b1;
    repeat (H) @(posedge clk);
    send_frame(8'h1C, 0, 0);
    check_errs("glitch_errs");
    read_check("glitch_frame");
  endtask

  task automatic test_makebreak();
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h74, 0, 0);
    check_status("mb_level");
    drain("mb_e0f074");
    send_frame(8'hF0, 0, 0);
    send_frame(8'h44, 1, 0);
    send_frame(8'h1C, 0, 0);
    check_errs("mb_parity");
    drain("mb_flush");
  endtask

  task automatic test_back_to_back();
    send_frame(8'hA5, 0, 0);
    send_frame(8'h3C, 0, 0);
    send_frame(8'hFF, 0, 0);
    check_status("b2b_level");
    drain("b2b_data");
  endtask

  task automatic test_reset_midframe();
    send_frame(8'h21, 0, 0);
    send_bits(11'b00000110110, 5);
    clrn = 1'b0;
    repeat (2) @(posedge clk);
    clrn = 1'b1;
    exp_q.delete();
    m_ovf = 0;
    m_ext = 0;
    m_brk = 0;
    check_status("midreset_status");
    repeat (2 * H) @(posedge clk);
    send_frame(8'h1C, 0, 0);
    read_check("midreset_frame");
    check_errs("midreset_errs");
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_stop_bit();
    test_timeout();
    test_overflow();
    test_push_pop_full();
    test_glitch();
    test_makebreak();
    test_back_to_back();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
